// File: rtl/pool_window_streamer.sv
// rtl/pool_window_streamer.sv - buffers KERNEL-row groups and replays KxK pooling windows serially
// Optional feature macro POOL_STREAM_PINGPONG_EN: second row-group buffer so fill overlaps drain.
module pool_window_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int KERNEL     = 2,
  parameter int MAX_W      = 64,
  parameter int GAP        = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [7:0]            cfg_map_width_i,
  input  logic [7:0]            cfg_map_height_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_first_o,
  output logic                  out_last_o,
  output logic [7:0]            data_num_o,
  output logic [7:0]            win_x_o,
  output logic [7:0]            win_y_o,
  output logic                  busy_o,
  output logic                  done_o
);
`ifdef POOL_STREAM_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int DEPTH = NBUF * KERNEL * MAX_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int KW    = $clog2(KERNEL);
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(KERNEL - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic          PP       = (NBUF == 2);

  typedef enum logic [1:0] {IN_IDLE, IN_FILL, IN_FLUSH, IN_WAIT} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_DRAIN, OUT_GAP} out_state_e;

  in_state_e  in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;

  logic [7:0]    w_q, w_d, h_q, h_d, wx_q, wx_d;
  logic [7:0]    kept_cols_q, kept_cols_d, kept_rows_q, kept_rows_d;
  logic [7:0]    col_q, col_d, row_q, row_d;
  logic [KW-1:0] slot_q, slot_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [7:0]    win_x_q, win_x_d, win_y_q, win_y_d;
  logic [KW-1:0] er_q, er_d, ec_q, ec_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    cfg_wx, cfg_kc, cfg_kr;
  logic          hs, row_end, last_hs, grp_done, grp_fire, wr_en, nb, nxt_ready;

  assign cfg_wx = cfg_map_width_i / 8'(KERNEL);
  assign cfg_kc = cfg_wx * 8'(KERNEL);
  assign cfg_kr = (cfg_map_height_i / 8'(KERNEL)) * 8'(KERNEL);

  assign in_ready_o = ((in_state_q == IN_FILL) || (in_state_q == IN_FLUSH)) && !full_q[wr_bank_q];
  assign hs         = in_valid_i && in_ready_o;
  assign row_end    = (col_q == w_q - 8'd1);
  assign last_hs    = hs && row_end && (row_q == h_q - 8'd1);
  assign grp_done   = hs && (in_state_q == IN_FILL) && row_end && (slot_q == K_LAST);
  assign grp_fire   = grp_done && (wx_q != 8'd0);
  assign wr_en      = hs && (in_state_q == IN_FILL) && (col_q < kept_cols_q);
  assign nb         = rd_bank_q ^ PP;
  // The other bank can only be ready when there is a second bank to hold it.
  assign nxt_ready  = PP && (full_q[nb] || (grp_fire && (wr_bank_q == nb)));

  assign wr_addr = AW'(int'(wr_bank_q) * KERNEL * MAX_W + int'(slot_q) * MAX_W + int'(col_q));
  assign rd_addr = AW'(int'(rd_bank_d) * KERNEL * MAX_W + int'(er_d) * MAX_W
                       + int'(win_x_d) * KERNEL + int'(ec_d));

  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    w_d = w_q; h_d = h_q; wx_d = wx_q;
    kept_cols_d = kept_cols_q; kept_rows_d = kept_rows_q;
    col_d = col_q; row_d = row_q; slot_d = slot_q;
    wr_bank_d = wr_bank_q; rd_bank_d = rd_bank_q; full_d = full_q;
    win_x_d = win_x_q; win_y_d = win_y_q; er_d = er_q; ec_d = ec_q; gap_d = gap_q;
    busy_d = busy_q; done_d = 1'b0;
    out_valid_d = 1'b0; out_first_d = 1'b0; out_last_d = 1'b0;

    case (in_state_q)
      IN_IDLE: begin
        if (start_i && !busy_q) begin
          w_d = cfg_map_width_i; h_d = cfg_map_height_i; wx_d = cfg_wx;
          kept_cols_d = cfg_kc; kept_rows_d = cfg_kr;
          col_d = 8'd0; row_d = 8'd0; slot_d = '0;
          win_x_d = 8'd0; win_y_d = 8'd0;
          wr_bank_d = 1'b0; rd_bank_d = 1'b0; full_d = 2'b00;
          if (cfg_map_width_i == 8'd0 || cfg_map_height_i == 8'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            in_state_d = (cfg_kr == 8'd0) ? IN_FLUSH : IN_FILL;
          end
        end
      end
      IN_FILL, IN_FLUSH: begin
        if (hs) begin
          col_d = row_end ? 8'd0 : col_q + 8'd1;
          if (row_end) begin
            row_d  = row_q + 8'd1;
            slot_d = (slot_q == K_LAST) ? '0 : slot_q + KW'(1);
          end
          if (last_hs) in_state_d = IN_WAIT;
          else if (grp_done && (row_q + 8'd1 == kept_rows_q)) in_state_d = IN_FLUSH;
        end
        if (grp_fire) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = wr_bank_q ^ PP;
        end
      end
      default: ;
    endcase

    case (out_state_q)
      OUT_IDLE: begin
        if (busy_q && (full_q[rd_bank_q] || (grp_fire && (wr_bank_q == rd_bank_q)))) begin
          out_state_d = OUT_DRAIN;
          win_x_d = 8'd0; er_d = '0; ec_d = '0;
          out_valid_d = 1'b1; out_first_d = 1'b1;
        end
      end
      OUT_DRAIN: begin
        if (er_q == K_LAST && ec_q == K_LAST) begin
          out_state_d = OUT_GAP;
          gap_d       = '0;
        end else begin
          out_valid_d = 1'b1;
          if (ec_q == K_LAST) begin
            ec_d = '0;
            er_d = er_q + KW'(1);
          end else begin
            ec_d = ec_q + KW'(1);
          end
          out_last_d = (er_d == K_LAST) && (ec_d == K_LAST);
        end
      end
      OUT_GAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + GW'(1);
        end else if (win_x_q != wx_q - 8'd1) begin
          out_state_d = OUT_DRAIN;
          win_x_d = win_x_q + 8'd1; er_d = '0; ec_d = '0;
          out_valid_d = 1'b1; out_first_d = 1'b1;
        end else begin
          // Row group fully emitted: release its buffer and chain straight into the other one.
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d = nb;
          win_y_d   = win_y_q + 8'd1;
          if (nxt_ready) begin
            out_state_d = OUT_DRAIN;
            win_x_d = 8'd0; er_d = '0; ec_d = '0;
            out_valid_d = 1'b1; out_first_d = 1'b1;
          end else begin
            out_state_d = OUT_IDLE;
          end
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase

    if (busy_q && ((in_state_q == IN_WAIT) || last_hs) &&
        (out_state_d == OUT_IDLE) && (full_d == 2'b00)) begin
      done_d     = 1'b1;
      busy_d     = 1'b0;
      in_state_d = IN_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      w_q <= '0; h_q <= '0; wx_q <= '0;
      kept_cols_q <= '0; kept_rows_q <= '0;
      col_q <= '0; row_q <= '0; slot_q <= '0;
      wr_bank_q <= 1'b0; rd_bank_q <= 1'b0; full_q <= 2'b00;
      win_x_q <= '0; win_y_q <= '0; er_q <= '0; ec_q <= '0; gap_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0;
      out_valid_q <= 1'b0; out_first_q <= 1'b0; out_last_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      w_q <= w_d; h_q <= h_d; wx_q <= wx_d;
      kept_cols_q <= kept_cols_d; kept_rows_q <= kept_rows_d;
      col_q <= col_d; row_q <= row_d; slot_q <= slot_d;
      wr_bank_q <= wr_bank_d; rd_bank_q <= rd_bank_d; full_q <= full_d;
      win_x_q <= win_x_d; win_y_q <= win_y_d; er_q <= er_d; ec_q <= ec_d; gap_q <= gap_d;
      busy_q <= busy_d; done_q <= done_d;
      out_valid_q <= out_valid_d; out_first_q <= out_first_d; out_last_q <= out_last_d;
      out_data_q  <= out_valid_d ? mem_q[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= in_data_i;
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;
  assign data_num_o  = 8'(KERNEL * KERNEL);
  assign win_x_o     = win_x_q;
  assign win_y_o     = win_y_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pool_window_streamer.sv
// tb/tb_pool_window_streamer.sv - randomized self-checking bench for pool_window_streamer
// Expected windows are derived from the map geometry; POOL_STREAM_PINGPONG_EN enables the overlap test.
module tb_pool_window_streamer;
  localparam int K   = 2;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, out_valid, out_first, out_last, busy, done;
  logic [7:0]  cfg_w, cfg_h, data_num, win_x, win_y;
  logic [15:0] in_data, out_data;

  always #5 clk = ~clk;

  pool_window_streamer #(.DATA_WIDTH(16), .KERNEL(K), .MAX_W(64), .GAP(GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .cfg_map_width_i(cfg_w), .cfg_map_height_i(cfg_h),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_first_o(out_first), .out_last_o(out_last),
    .data_num_o(data_num), .win_x_o(win_x), .win_y_o(win_y), .busy_o(busy), .done_o(done)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] pix[$];
  logic [15:0] o_data[$];
  bit          o_first[$], o_last[$];
  int          o_wx[$], o_wy[$], o_cyc[$];
  int          cyc_cnt = 0, hs_cnt, done_cnt, rdy_viol, idle_nonzero, gap_left, start_cyc, done_cyc;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (mon_en) begin
      if (start && start_cyc < 0) start_cyc = cyc_cnt;
      if (in_valid && in_ready) hs_cnt++;
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc_cnt;
        done_cnt++;
      end
      if (out_valid) begin
        o_data.push_back(out_data); o_first.push_back(out_first); o_last.push_back(out_last);
        o_wx.push_back(int'(win_x)); o_wy.push_back(int'(win_y)); o_cyc.push_back(cyc_cnt);
        if (in_ready) rdy_viol++;
        gap_left = out_last ? GAP : 0;
      end else begin
        if (out_data != 16'h0 || out_first || out_last) idle_nonzero++;
        if (gap_left > 0) begin
          if (in_ready) rdy_viol++;
          gap_left--;
        end
      end
    end
  end

  task automatic clear_obs();
    o_data.delete(); o_first.delete(); o_last.delete();
    o_wx.delete(); o_wy.delete(); o_cyc.delete();
    hs_cnt = 0; done_cnt = 0; rdy_viol = 0; idle_nonzero = 0; gap_left = 0;
    start_cyc = -1; done_cyc = -1;
  endtask

  // mode 0: valid always, 1: every other cycle, 2: always + stray start mid-fill, 3: random valid
  task automatic run_map(input int w, input int h, input int mode, output int drops);
    int idx = 0;
    int budget = 8 * w * h + 300;
    drops = 0;
    pix.delete();
    for (int i = 0; i < w * h; i++) pix.push_back(16'($urandom));
    clear_obs();
    mon_en = 1'b1;
    @(posedge clk); #1;
    cfg_w = 8'(w); cfg_h = 8'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      in_valid = (idx < w * h) && (mode == 1 ? (c % 2 == 0) : mode == 3 ? ($urandom % 2 == 1) : 1'b1);
      in_data  = in_valid ? pix[idx] : 16'h0;
      if (mode == 2 && c == 3) begin
        start = 1'b1; cfg_w = 8'd8; cfg_h = 8'd8;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_valid && !in_ready) drops++;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0;
    repeat (GAP + 6) @(posedge clk);
    #1;
    mon_en = 1'b0;
  endtask

  function automatic int elem_errs(input int w, input int h);
    int errs = 0;
    int n = 0;
    int nwx = w / K;
    int nwy = h / K;
    if (o_data.size() != nwx * nwy * K * K) return 1000 + o_data.size();
    for (int y = 0; y < nwy; y++)
      for (int x = 0; x < nwx; x++)
        for (int e = 0; e < K * K; e++) begin
          logic [15:0] ev = pix[(y * K + e / K) * w + x * K + e % K];
          if (o_data[n] !== ev || o_first[n] != (e == 0) || o_last[n] != (e == K * K - 1) ||
              o_wx[n] != x || o_wy[n] != y) errs++;
          n++;
        end
    return errs;
  endfunction

  function automatic int gap_errs(input bit strict);
    int errs = 0;
    for (int i = 0; i + 1 < o_cyc.size(); i++) begin
      int d = o_cyc[i + 1] - o_cyc[i];
      if (!o_last[i]) begin
        if (d != 1) errs++;
      end else if (strict || o_wy[i + 1] == o_wy[i]) begin
        if (d != GAP + 1) errs++;
      end else if (d < GAP + 1) begin
        errs++;
      end
    end
    return errs;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'h0; cfg_w = 8'd0; cfg_h = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_first, out_last, busy, done, in_ready} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=000000", {out_valid, out_first, out_last, busy, done, in_ready});
    end
    checks++;
    if ({out_data, win_x, win_y} !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h want=0", {out_data, win_x, win_y});
    end
    checks++;
    if (data_num !== 8'(K * K)) begin
      failures++; $display("FAIL reset_data_num got=%0d want=%0d", data_num, K * K);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_4x4();
    int drops, e;
    run_map(4, 4, 0, drops);
    e = elem_errs(4, 4);
    checks++; if (e !== 0) begin failures++; $display("FAIL basic_elems errs=%0d want=0", e); end
    e = gap_errs(1'b0);
    checks++; if (e !== 0) begin failures++; $display("FAIL basic_spacing errs=%0d want=0", e); end
    checks++; if (hs_cnt !== 16) begin failures++; $display("FAIL basic_handshakes got=%0d want=16", hs_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done got=%0d want=1", done_cnt); end
    checks++; if (idle_nonzero !== 0) begin failures++; $display("FAIL basic_idle_zero got=%0d want=0", idle_nonzero); end
    checks++; if (data_num !== 8'd4) begin failures++; $display("FAIL basic_data_num got=%0d want=4", data_num); end
  endtask

  task automatic test_crop_5x5();
    int drops, e;
    run_map(5, 5, 0, drops);
    e = elem_errs(5, 5);
    checks++; if (e !== 0) begin failures++; $display("FAIL crop_elems errs=%0d want=0", e); end
    checks++; if (hs_cnt !== 25) begin failures++; $display("FAIL crop_handshakes got=%0d want=25", hs_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL crop_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_toggle_valid();
    int drops, e;
    run_map(4, 4, 1, drops);
    e = elem_errs(4, 4);
    checks++; if (e !== 0) begin failures++; $display("FAIL toggle_elems errs=%0d want=0", e); end
    checks++; if (hs_cnt !== 16) begin failures++; $display("FAIL toggle_handshakes got=%0d want=16", hs_cnt); end
`ifndef POOL_STREAM_PINGPONG_EN
    checks++; if (rdy_viol !== 0) begin failures++; $display("FAIL toggle_ready_in_drain got=%0d want=0", rdy_viol); end
`endif
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int drops, e;
    bit hit = 1'b0;
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(16'($urandom));
    clear_obs();
    mon_en = 1'b1;
    @(posedge clk); #1;
    cfg_w = 8'd4; cfg_h = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      in_valid = (idx < 16);
      in_data  = in_valid ? pix[idx] : 16'h0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (o_data.size() >= 5) hit = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_window2 got=%0d elems want>=5", o_data.size()); end
    rst_n = 1'b0; in_valid = 1'b0; mon_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_first, out_last, busy, done, in_ready} !== 6'b0 || {out_data, win_x, win_y} !== 32'h0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%h want=0", {out_valid, out_first, out_last, busy, done, in_ready}, {out_data, win_x, win_y});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_map(2, 2, 0, drops);
    e = elem_errs(2, 2);
    checks++; if (e !== 0) begin failures++; $display("FAIL rstmid_2x2_elems errs=%0d want=0", e); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rstmid_2x2_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    int drops, e;
    run_map(4, 4, 2, drops);
    e = elem_errs(4, 4);
    checks++; if (e !== 0) begin failures++; $display("FAIL restart_elems errs=%0d want=0", e); end
    checks++; if (hs_cnt !== 16) begin failures++; $display("FAIL restart_handshakes got=%0d want=16", hs_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_degenerate();
    int drops;
    run_map(1, 3, 0, drops);
    checks++; if (o_data.size() !== 0) begin failures++; $display("FAIL narrow_no_output got=%0d want=0", o_data.size()); end
    checks++; if (hs_cnt !== 3) begin failures++; $display("FAIL narrow_handshakes got=%0d want=3", hs_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL narrow_done got=%0d want=1", done_cnt); end
    run_map(0, 5, 0, drops);
    checks++; if (done_cyc - start_cyc !== 1) begin failures++; $display("FAIL zero_done_latency got=%0d want=1", done_cyc - start_cyc); end
    checks++; if (done_cnt !== 1 || hs_cnt !== 0) begin failures++; $display("FAIL zero_done_hs got=%0d/%0d want=1/0", done_cnt, hs_cnt); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int w = $urandom_range(0, 9);
      int h = $urandom_range(0, 9);
      int drops, e;
      run_map(w, h, 3, drops);
      e = elem_errs(w, h) + gap_errs(1'b0);
      checks++; if (e !== 0) begin failures++; $display("FAIL rand_%0dx%0d_windows errs=%0d want=0", w, h, e); end
      checks++; if (hs_cnt !== w * h || done_cnt !== 1) begin
        failures++; $display("FAIL rand_%0dx%0d_hs_done got=%0d/%0d want=%0d/1", w, h, hs_cnt, done_cnt, w * h);
      end
`ifndef POOL_STREAM_PINGPONG_EN
      checks++; if (rdy_viol !== 0) begin failures++; $display("FAIL rand_%0dx%0d_ready_in_drain got=%0d want=0", w, h, rdy_viol); end
`endif
    end
  endtask

`ifdef POOL_STREAM_PINGPONG_EN
  task automatic test_pingpong();
    int drops, e;
    run_map(8, 4, 0, drops);
    checks++; if (drops !== 0) begin failures++; $display("FAIL pp_ready_drops got=%0d want=0", drops); end
    e = elem_errs(8, 4);
    checks++; if (e !== 0) begin failures++; $display("FAIL pp_elems errs=%0d want=0", e); end
    e = gap_errs(1'b1);
    checks++; if (e !== 0) begin failures++; $display("FAIL pp_back_to_back errs=%0d want=0", e); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_4x4();
    test_crop_5x5();
    test_toggle_valid();
    test_reset_mid();
    test_start_ignored();
    test_degenerate();
    test_random();
`ifdef POOL_STREAM_PINGPONG_EN
    test_pingpong();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
